class_decision_tracker: RTL and testbench
=========================================

# class_decision_tracker

Consumes the per-frame 2-bit class code produced by the network's final layer and turns it into confirmed word events. A word is reported only after `CONFIRM_CNT` consecutive valid frames carry the same non-silence class. Each event is held on a valid/ready handshake until the downstream consumer (LED/UART/display logic) accepts it. A hold-off window of `HOLDOFF_FRAMES` frames then follows, so one utterance produces exactly one event.

## Interface
Parameters:
- `CONFIRM_CNT`, 4 — consecutive identical frames required; legal range 1..15.
- `HOLDOFF_FRAMES`, 8 — frames ignored after an accepted event; legal range 0..255.

Ports:
- `clk`  in  1  — system clock.
- `rst`  in  1  — reset, asynchronous, active-high.
- `class_in`  in  2  — frame class: 00 silence/none, 01 word A, 10 word B, 11 invalid.
- `class_valid`  in  1  — `class_in` is valid this cycle; single-cycle strobe per frame.
- `word_out`  out  2  — confirmed class (01 or 10); 00 when no event is pending.
- `word_valid`  out  1  — event pending.
- `word_ready`  in  1  — consumer accepts the event.
- `frame_dropped`  out  1  — 1-cycle pulse: a frame arrived in PENDING and was discarded.
- `busy`  out  1  — state is PENDING or HOLDOFF.
- `det_cnt_a`  out  16  — accepted word-A events (see Configuration).
- `det_cnt_b`  out  16  — accepted word-B events (see Configuration).

## Operation
- FSM states: TRACK, PENDING, HOLDOFF. Reset state is TRACK.
- Internal registers:
  - `cand` (2 b): current candidate class.
  - `streak` (4 b): consecutive-frame count for `cand`.
  - `hold` (8 b): remaining hold-off frames.
- TRACK, on `class_valid`:
  - `class_in` is 00 or 11: set `cand`=00, `streak`=0.
  - `class_in` is non-zero and ≠ `cand`: set `cand`=`class_in`, `streak`=1.
  - `class_in` = `cand` (non-zero): `streak`+1.
  - Whenever the new streak value equals `CONFIRM_CNT`: set `word_out`=`cand`, `word_valid`=1, `streak`=0, go to PENDING. This includes the `CONFIRM_CNT`=1 case on the first frame.
- TRACK without `class_valid`: all registers hold; gaps between frames do not break a streak.
- PENDING:
  - `word_valid`=1 and `word_out` stay stable until `word_valid && word_ready`.
  - Any `class_valid` in this state raises `frame_dropped` for one cycle; the frame is discarded.
- Handshake in PENDING:
  - `word_out` returns to 00 and `word_valid` to 0; `cand`=00.
  - If `HOLDOFF_FRAMES`=0, go to TRACK; otherwise load `hold`=`HOLDOFF_FRAMES` and go to HOLDOFF.
- HOLDOFF:
  - Each `class_valid` decrements `hold`. The frame is not tracked and not counted as dropped.
  - A `class_valid` seen while `hold`=1 goes to TRACK. That frame is consumed, not used to seed `cand`.
- `word_ready` outside PENDING is ignored.
- `busy` = (state ≠ TRACK), driven from registered state.

## Timing
- All outputs are registered. Reset values: `word_out`=00, `word_valid`=0, `frame_dropped`=0, `busy`=0, `det_cnt_a`=`det_cnt_b`=0.
- Detection latency: `word_valid` rises on the clock edge that samples the `CONFIRM_CNT`-th matching `class_valid`, so it is visible from the following cycle.
- Handshake: the transfer occurs on the edge where `word_valid && word_ready`. `word_valid` is low from the next cycle. No combinational path from `word_ready` to any output.
- `word_ready` may be held high permanently. Each event is then accepted on its first `word_valid` cycle, and the design moves to HOLDOFF/TRACK one cycle after detection.
- `frame_dropped` is asserted for exactly the cycle after the discarded `class_valid`.
- Asynchronous `rst` assertion mid-operation, in any state, immediately forces all outputs and registers to reset values. Operation resumes in TRACK with `streak`=0 on the first edge after deassertion.

## Configuration
- Macro `DECISION_STATS_EN`.
- Defined:
  - `det_cnt_a` / `det_cnt_b` increment on each accepted handshake of word 01 / 10 respectively.
  - Counters saturate at 0xFFFF.
  - Counters are cleared only by `rst`.
- Undefined: counter logic is not compiled, and both ports are tied to 16'h0000. The ports remain present so the top level is unchanged.

## Test plan
- Defaults, `word_ready`=1: frames 01,01,01,01 → `word_out`=01 and `word_valid` high for one cycle after the 4th frame; `busy`=1; the next 8 frames are ignored, then TRACK.
- Frames 10,10,10,00,10,10,10,10 → no event after the first three 10s; a single 10 event after the 8th frame.
- Frames 01,01,10,10,10,10 → `cand` switches at the 3rd frame; a word-B event fires on the 6th frame.
- `word_ready`=0 for 20 cycles with 3 frames arriving during PENDING → `word_valid` and `word_out` stay stable; three `frame_dropped` pulses. Raising `word_ready` → handshake, then HOLDOFF.
- `rst` pulsed mid-streak (after 3 frames of 01) and mid-PENDING → all outputs 0 immediately. After release, 4 more frames of 01 are needed for an event.
- With `DECISION_STATS_EN`: 3 A events and 2 B events → `det_cnt_a`=3, `det_cnt_b`=2. Preload near 0xFFFF and confirm saturation. Without the macro, both counters read 0.

Source files
------------

// File: rtl/class_decision_tracker.sv
// class_decision_tracker: confirms repeated non-silence frame classes into word events with handshake and hold-off.
// Define DECISION_STATS_EN to enable the saturating per-word event counters.
module class_decision_tracker #(
    parameter int CONFIRM_CNT    = 4,
    parameter int HOLDOFF_FRAMES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  class_in,
    input  logic        class_valid,
    output logic [1:0]  word_out,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        frame_dropped,
    output logic        busy,
    output logic [15:0] det_cnt_a,
    output logic [15:0] det_cnt_b
);
    typedef enum logic [1:0] {TRACK, PENDING, HOLDOFF} state_t;
    state_t      state;
    logic [1:0]  cand, ncand;
    logic [3:0]  streak, nstreak;
    logic [7:0]  hold;
    logic        bad, hit, accept;

    always_comb begin
        bad     = (class_in == 2'b00) || (class_in == 2'b11);
        ncand   = bad ? 2'b00 : class_in;
        nstreak = bad ? 4'd0 : (class_in != cand) ? 4'd1 : streak + 4'd1;
        hit     = !bad && (nstreak == 4'(CONFIRM_CNT));
        accept  = (state == PENDING) && word_valid && word_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= TRACK;
            cand          <= 2'b00;
            streak        <= 4'd0;
            hold          <= 8'd0;
            word_out      <= 2'b00;
            word_valid    <= 1'b0;
            frame_dropped <= 1'b0;
            busy          <= 1'b0;
        end else begin
            frame_dropped <= 1'b0;
            case (state)
                TRACK: if (class_valid) begin
                    cand   <= ncand;
                    streak <= hit ? 4'd0 : nstreak;
                    if (hit) begin
                        word_out   <= ncand;
                        word_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= PENDING;
                    end
                end
                PENDING: begin
                    frame_dropped <= class_valid;
                    if (accept) begin
                        word_out   <= 2'b00;
                        word_valid <= 1'b0;
                        cand       <= 2'b00;
                        hold       <= 8'(HOLDOFF_FRAMES);
                        busy       <= (HOLDOFF_FRAMES != 0);
                        state      <= (HOLDOFF_FRAMES != 0) ? HOLDOFF : TRACK;
                    end
                end
                HOLDOFF: if (class_valid) begin
                    // Frames here are consumed outright; the last one does not seed a candidate.
                    hold <= hold - 8'd1;
                    if (hold == 8'd1) begin
                        busy  <= 1'b0;
                        state <= TRACK;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= TRACK;
                end
            endcase
        end
    end

`ifdef DECISION_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            det_cnt_a <= 16'h0000;
            det_cnt_b <= 16'h0000;
        end else if (accept) begin
            if (word_out == 2'b01 && det_cnt_a != 16'hFFFF) det_cnt_a <= det_cnt_a + 16'd1;
            if (word_out == 2'b10 && det_cnt_b != 16'hFFFF) det_cnt_b <= det_cnt_b + 16'd1;
        end
    end
`else
    assign det_cnt_a = 16'h0000;
    assign det_cnt_b = 16'h0000;
`endif
endmodule

// File: tb/tb_class_decision_tracker.sv
// tb_class_decision_tracker: directed vectors with hand-computed expectations for class_decision_tracker (defaults 4/8).
module tb_class_decision_tracker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  class_in = 2'b00;
    logic        class_valid = 1'b0;
    logic [1:0]  word_out;
    logic        word_valid;
    logic        word_ready = 1'b1;
    logic        frame_dropped;
    logic        busy;
    logic [15:0] det_cnt_a, det_cnt_b;
    int          n_vec = 0;
    int          n_err = 0;
    int          exp_a, exp_b;

    class_decision_tracker dut (
        .clk(clk), .rst(rst), .class_in(class_in), .class_valid(class_valid),
        .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .frame_dropped(frame_dropped), .busy(busy),
        .det_cnt_a(det_cnt_a), .det_cnt_b(det_cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns on the negedge after the sampling edge, so that edge's results are visible.
    task automatic frame(input logic [1:0] c);
        @(negedge clk);
        class_in = c;
        class_valid = 1'b1;
        @(negedge clk);
        class_valid = 1'b0;
        class_in = 2'b00;
    endtask

    task automatic holdoff(input logic [1:0] c);
        for (int i = 0; i < 8; i++) frame(c);
    endtask

    task automatic word_event(input logic [1:0] c);
        for (int i = 0; i < 4; i++) frame(c);
        holdoff(2'b00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        idle(2);
        chk("rst_word_out", 16'(word_out), 16'h0);
        chk("rst_word_valid", 16'(word_valid), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_dropped", 16'(frame_dropped), 16'h0);
        chk("rst_cnt_a", det_cnt_a, 16'h0);
        rst = 1'b0;
        // A,A,A,A with ready held high
        for (int i = 0; i < 3; i++) frame(2'b01);
        chk("a3_no_event", 16'(word_valid), 16'h0);
        frame(2'b01);
        chk("a4_valid", 16'(word_valid), 16'h1);
        chk("a4_word", 16'(word_out), 16'h1);
        chk("a4_busy", 16'(busy), 16'h1);
        idle(1);
        chk("a_accept_valid", 16'(word_valid), 16'h0);
        chk("a_accept_word", 16'(word_out), 16'h0);
        chk("a_holdoff_busy", 16'(busy), 16'h1);
        for (int i = 0; i < 7; i++) frame(2'b01);
        chk("holdoff7_busy", 16'(busy), 16'h1);
        chk("holdoff_no_drop", 16'(frame_dropped), 16'h0);
        frame(2'b01);
        chk("holdoff8_busy", 16'(busy), 16'h0);
        // holdoff frames must not have seeded the candidate
        for (int i = 0; i < 3; i++) frame(2'b01);
        chk("post_hold_a3", 16'(word_valid), 16'h0);
        frame(2'b01);
        chk("post_hold_a4", 16'(word_valid), 16'h1);
        holdoff(2'b00);
        // B,B,B,silence breaks the streak
        frame(2'b10); frame(2'b10); frame(2'b10); frame(2'b00);
        frame(2'b10); frame(2'b10); frame(2'b10);
        chk("b_broken_no_event", 16'(word_valid), 16'h0);
        frame(2'b10);
        chk("b8_valid", 16'(word_valid), 16'h1);
        chk("b8_word", 16'(word_out), 16'h2);
        holdoff(2'b00);
        chk("b_holdoff_done", 16'(busy), 16'h0);
        // candidate switch A->B
        frame(2'b01); frame(2'b01); frame(2'b10); frame(2'b10); frame(2'b10);
        chk("switch5_no_event", 16'(word_valid), 16'h0);
        frame(2'b10);
        chk("switch6_word", 16'(word_out), 16'h2);
        holdoff(2'b00);
        // backpressure: 20 cycles of ready low with 3 dropped frames
        word_ready = 1'b0;
        for (int i = 0; i < 4; i++) frame(2'b01);
        for (int i = 0; i < 3; i++) begin
            frame(2'b10);
            chk("bp_dropped", 16'(frame_dropped), 16'h1);
            chk("bp_valid", 16'(word_valid), 16'h1);
            chk("bp_word", 16'(word_out), 16'h1);
            idle(4);
            chk("bp_drop_cleared", 16'(frame_dropped), 16'h0);
        end
        idle(5);
        chk("bp_still_valid", 16'(word_valid), 16'h1);
        word_ready = 1'b1;
        idle(1);
        chk("bp_accept_valid", 16'(word_valid), 16'h0);
        chk("bp_accept_busy", 16'(busy), 16'h1);
        holdoff(2'b11);
        chk("bp_holdoff_done", 16'(busy), 16'h0);
        // async reset mid-PENDING
        word_ready = 1'b0;
        for (int i = 0; i < 4; i++) frame(2'b10);
        #2 rst = 1'b1;
        #1;
        chk("rst_pend_valid", 16'(word_valid), 16'h0);
        chk("rst_pend_word", 16'(word_out), 16'h0);
        chk("rst_pend_busy", 16'(busy), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        word_ready = 1'b1;
        // async reset mid-streak
        for (int i = 0; i < 3; i++) frame(2'b01);
        #2 rst = 1'b1;
        #1;
        chk("rst_streak_valid", 16'(word_valid), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) frame(2'b01);
        chk("rst_streak_restart3", 16'(word_valid), 16'h0);
        frame(2'b01);
        chk("rst_streak_restart4", 16'(word_valid), 16'h1);
        holdoff(2'b00);
        // statistics after a clean reset
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) word_event(2'b01);
        for (int i = 0; i < 2; i++) word_event(2'b10);
`ifdef DECISION_STATS_EN
        exp_a = 3; exp_b = 2;
`else
        exp_a = 0; exp_b = 0;
`endif
        chk("cnt_a", det_cnt_a, 16'(exp_a));
        chk("cnt_b", det_cnt_b, 16'(exp_b));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
